spi_cfg_regbank: RTL and testbench
==================================

Name: spi_cfg_regbank

Overview:
SPI mode 0 slave register bank that sequences byte-framed transactions and holds configuration registers for downstream logic. The first byte of each frame is a command: read/write flag plus a 7-bit start address. Following bytes are data, and the address auto-increments after each data byte. The block runs entirely in the sclk domain. Its register contents are exported as a flat configuration bus.

Parameters:
NREGS, 8, number of read/write config registers at addresses 0..NREGS-1 (1..127)
RESET_VAL, 8'h00, reset value of every config register
ID_VAL, 8'hA5, read-only value returned at address 7'h7F

Ports:
sclk  input  1  SPI clock; idle low (CPOL=0)
rst  input  1  asynchronous, active-high reset
ss_n  input  1  slave select, active low; high = asynchronous frame abort/idle
mosi  input  1  serial data in, MSB first, sampled on sclk rising edge
miso  output  1  serial data out, MSB first, changes on sclk falling edge
miso_oe  output  1  pad output enable, equal to ~ss_n
cfg  output  NREGS*8  config registers; reg k is cfg[8k+7:8k]

Behaviour:
- Reset, asynchronous on rst high:
  - all config regs = RESET_VAL;
  - state = CMD, bit_cnt = 0, rx_shift = 0, tx_shift = 0, addr = 0, rw = 0;
  - miso = 0.
- ss_n high, asynchronous, without rst:
  - clears state to CMD, bit_cnt, rx_shift and tx_shift;
  - config regs keep their values;
  - a partially shifted byte is discarded with no write.
- Framing:
  - 3-bit bit_cnt advances on each rising edge while ss_n is low, wrapping 7->0.
  - The 8th rising edge is the edge where bit_cnt==7. The byte completed on that edge is {rx_shift[6:0], mosi}.
- State machine: two states.
  - CMD: on the 8th rising edge, rw <= byte[7] (1 = read), addr <= byte[6:0], then go to DATA.
  - DATA: on each 8th rising edge:
    - if rw=0 and addr<NREGS, reg[addr] <= byte on that same edge;
    - writes to addr>=NREGS, including 7'h7F, are ignored;
    - then addr <= addr+1, wrapping modulo 128 (7'h7F -> 7'h00);
    - remain in DATA until ss_n goes high.
- Read mux:
  - addr<NREGS returns reg[addr];
  - addr==7'h7F returns ID_VAL;
  - all other addresses return 8'h00.
- MISO path:
  - miso = tx_shift[7].
  - On each falling edge with bit_cnt==0 and state==DATA and rw=1, tx_shift <= rd_mux(addr). This load makes bit 7 valid before the first rising edge of the data byte.
  - On all other falling edges, tx_shift <= {tx_shift[6:0],0}.
  - miso is 0 during the command byte and throughout write frames.
- Read-after-write within the same frame is impossible, because the address increments past written locations. A new frame reads the updated value.
- Latency:
  - a write becomes visible on cfg at the 8th rising edge of the data byte;
  - a read byte's MSB appears at the falling edge after the command's 8th rising edge.
- Simultaneous events:
  - rst dominates ss_n.
  - ss_n rising at the same time as the 8th sclk rising edge is a protocol violation; the write is not guaranteed.
- Bursts longer than 128 data bytes wrap the address and continue.

Decomposition:
- Shared package spi_cfg_pkg holds:
  - CMD_RW_BIT=7;
  - ADDR_W=7;
  - ID_ADDR=7'h7F;
  - state encoding ST_CMD/ST_DATA.
- One sub-module: spi_byte_framer. It contains bit_cnt, rx_shift and tx_shift with async clear on ~ss_n|rst. It outputs byte_done, rx_byte and byte_start, and accepts a tx_load/tx_byte pair.
- The top holds the FSM, addr/rw registers, register file and read mux.

Test Plan:
- Apply rst, then check cfg: all bytes 8'h00 and miso=0; miso_oe=0 while ss_n=1.
- Write frame 0x02,0x11,0x22 -> reg2=0x11 and reg3=0x22 at their 8th rising edges; other regs unchanged.
- Read frame 0x82 followed by two dummy bytes -> miso shifts 0x11 then 0x22, MSB first, each bit stable across its rising edge.
- Read frame 0xFF followed by two dummy bytes -> returns ID_VAL 0xA5 then 0x00 (address wraps to 0, where reg0 = 0x00). A write frame 0x7F,0x55 leaves all cfg unchanged.
- Write frame 0x05 then 5 bits of 0x3C, then ss_n high -> reg5 unchanged. A fresh write frame 0x05,0x3C then sets reg5=0x3C, showing the framer resynchronises.
- Assert rst mid-burst during a write of 0x06,0x77 after 4 data bits -> all regs return to RESET_VAL and the next frame decodes normally.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM encoding for the SPI configuration register bank.
package spi_cfg_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam logic [ADDR_W-1:0] ID_ADDR = 7'h7F;

    typedef enum logic {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/spi_byte_framer.sv
// SPI mode 0 bit/byte framer. It is held clear whenever slave select is high, so
// a partial byte never reaches the register bank.
module spi_byte_framer (
    input  logic       sclk,
    input  logic       rst,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    input  logic       i_tx_load,
    input  logic [7:0] i_tx_byte,
    output logic       o_byte_done,
    output logic       o_byte_start,
    output logic [7:0] o_rx_byte,
    output logic       o_miso
);

    logic       w_clr;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;

    assign w_clr = rst | i_ss_n;

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge w_clr) begin
        if (w_clr) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_rx_shift <= {r_rx_shift[5:0], i_mosi};
        end
    end

    // Transmit side moves on the falling edge so MISO is settled before the master samples.
    always_ff @(negedge sclk or posedge w_clr) begin
        if (w_clr) begin
            r_tx_shift <= '0;
        end else if (i_tx_load) begin
            r_tx_shift <= i_tx_byte;
        end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
    end

    assign o_byte_done  = (r_bit_cnt == 3'd7);
    assign o_byte_start = (r_bit_cnt == 3'd0);
    assign o_rx_byte    = {r_rx_shift, i_mosi};
    assign o_miso       = r_tx_shift[7];

endmodule

// File: rtl/spi_cfg_regbank.sv
// SPI mode 0 slave configuration register bank: command byte (rw + start address)
// followed by auto-incrementing data bytes; registers are exported on cfg.
module spi_cfg_regbank
    import spi_cfg_pkg::*;
#(
    parameter int         NREGS     = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] ID_VAL    = 8'hA5
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic [NREGS*8-1:0] cfg
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [7:0]        r_regs [NREGS];

    logic       w_frame_clr;
    logic       w_byte_done;
    logic       w_byte_start;
    logic [7:0] w_rx_byte;
    logic       w_tx_load;
    logic [7:0] w_rd_data;
    logic       w_wr_en;

    assign w_frame_clr = rst | ss_n;

    spi_byte_framer u_framer (
        .sclk         (sclk),
        .rst          (rst),
        .i_ss_n       (ss_n),
        .i_mosi       (mosi),
        .i_tx_load    (w_tx_load),
        .i_tx_byte    (w_rd_data),
        .o_byte_done  (w_byte_done),
        .o_byte_start (w_byte_start),
        .o_rx_byte    (w_rx_byte),
        .o_miso       (miso)
    );

    always_ff @(posedge sclk or posedge w_frame_clr) begin
        if (w_frame_clr) begin
            r_state <= ST_CMD;
        end else begin
            case (r_state)
                ST_CMD:  if (w_byte_done) r_state <= ST_DATA;
                ST_DATA: r_state <= ST_DATA;
                default: r_state <= ST_CMD;
            endcase
        end
    end

    // Address and direction survive a frame abort; the next command byte reloads them.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_rw   <= 1'b0;
            r_addr <= '0;
        end else if (w_byte_done) begin
            if (r_state == ST_CMD) begin
                r_rw   <= w_rx_byte[CMD_RW_BIT];
                r_addr <= w_rx_byte[ADDR_W-1:0];
            end else begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign w_wr_en = (r_state == ST_DATA) && !r_rw && w_byte_done;

    // NOTE: the register file is a handful of flops, not a RAM, so it is safe to reset it.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= RESET_VAL;
        end else if (w_wr_en) begin
            for (int k = 0; k < NREGS; k++) begin
                if (r_addr == ADDR_W'(k)) r_regs[k] <= w_rx_byte;
            end
        end
    end

    // NOTE: default assignment first so this block can never infer a latch.
    always_comb begin
        w_rd_data = 8'h00;
        if (r_addr == ID_ADDR) w_rd_data = ID_VAL;
        for (int k = 0; k < NREGS; k++) begin
            if (r_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
        end
    end

    assign w_tx_load = (r_state == ST_DATA) && r_rw && w_byte_start;
    assign miso_oe   = ~ss_n;

    for (genvar g = 0; g < NREGS; g++) begin : g_cfg
        assign cfg[g*8 +: 8] = r_regs[g];
    end

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Randomised scoreboard bench for spi_cfg_regbank against a byte-level register model.
module tb_spi_cfg_regbank;

    localparam int         NR  = 8;
    localparam logic [7:0] IDV = 8'hA5;

    logic            sclk = 1'b0;
    logic            rst  = 1'b0;
    logic            ss_n = 1'b1;
    logic            mosi = 1'b0;
    wire             miso;
    wire             miso_oe;
    wire [NR*8-1:0]  cfg;

    spi_cfg_regbank #(.NREGS(NR), .RESET_VAL(8'h00), .ID_VAL(IDV)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .cfg     (cfg)
    );

    typedef struct {
        logic [7:0]     miso_b;
        logic [NR*8-1:0] cfg_v;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_regs [NR];
    logic       m_first;
    logic       m_rw;
    int         m_addr;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < NR) return m_regs[a];
        if (a == 127) return IDV;
        return 8'h00;
    endfunction

    function automatic logic [NR*8-1:0] m_cfg();
        logic [NR*8-1:0] v;
        for (int k = 0; k < NR; k++) v[k*8 +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #10 sclk = 1'b1;
            #10 sclk = 1'b0;
        end
    endtask

    // Model one full byte, queue what the DUT must show when it completes, then shift it.
    task automatic issue_byte(input logic [7:0] b);
        exp_t e;
        if (m_first) begin
            e.miso_b = 8'h00;
            m_rw     = b[7];
            m_addr   = int'(b[6:0]);
            m_first  = 1'b0;
        end else begin
            e.miso_b = m_rw ? m_read(m_addr) : 8'h00;
            if (!m_rw && m_addr < NR) m_regs[m_addr] = b;
            m_addr = (m_addr + 1) % 128;
        end
        e.cfg_v = m_cfg();
        sb_q.push_back(e);
        send_bits(b, 8);
    endtask

    task automatic frame(input logic [7:0] bytes[$]);
        ss_n    = 1'b0;
        m_first = 1'b1;
        #10;
        foreach (bytes[i]) issue_byte(bytes[i]);
        #10 ss_n = 1'b1;
        #20;
    endtask

    // Monitor: assembles MISO bytes at rising edges and checks them against the scoreboard.
    int         mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_unstable = 1'b0;

    always @(posedge ss_n or posedge rst) begin
        mon_bits     = 0;
        mon_unstable = 1'b0;
    end

    initial begin
        logic pre;
        exp_t e;
        forever begin
            @(posedge sclk);
            if (!ss_n && !rst) begin
                pre = miso;
                #1;
                if (miso !== pre) mon_unstable = 1'b1;
                mon_byte = {mon_byte[6:0], pre};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow actual=byte expected=none t=%0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("miso_byte", 64'(mon_byte), 64'(e.miso_b));
                        check("cfg_at_byte", 64'(cfg), 64'(e.cfg_v));
                        check("miso_stable", 64'(mon_unstable), 64'(0));
                    end
                    mon_unstable = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] cmd;
        int         n;
        m_reset();

        rst = 1'b1;
        #15 rst = 1'b0;
        #5;
        check("reset_cfg", 64'(cfg), 64'(0));
        check("reset_miso", 64'(miso), 64'(0));
        check("idle_miso_oe", 64'(miso_oe), 64'(0));
        ss_n = 1'b0;
        #1 check("sel_miso_oe", 64'(miso_oe), 64'(1));
        ss_n = 1'b1;
        #10;

        q = {8'h02, 8'h11, 8'h22};  frame(q);
        q = {8'h82, 8'h00, 8'h00};  frame(q);
        q = {8'hFF, 8'h00, 8'h00};  frame(q);
        q = {8'h7F, 8'h55};         frame(q);

        // Aborted write: command plus 5 data bits, then deselect.
        ss_n    = 1'b0;
        m_first = 1'b1;
        #10;
        issue_byte(8'h05);
        send_bits(8'h3C, 5);
        #10 ss_n = 1'b1;
        #20;
        check("abort_no_write", 64'(cfg), 64'(m_cfg()));
        q = {8'h05, 8'h3C};         frame(q);
        q = {8'h85, 8'h00};         frame(q);

        // Reset in the middle of a write burst.
        ss_n    = 1'b0;
        m_first = 1'b1;
        #10;
        issue_byte(8'h06);
        send_bits(8'h77, 4);
        #5 rst = 1'b1;
        #10 rst = 1'b0;
        m_reset();
        ss_n = 1'b1;
        #20;
        check("midburst_rst_cfg", 64'(cfg), 64'(0));
        check("midburst_rst_miso", 64'(miso), 64'(0));
        q = {8'h01, 8'hAB, 8'hCD, 8'hEF};  frame(q);
        q = {8'h80, 8'h00, 8'h00, 8'h00, 8'h00}; frame(q);

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'h7F - 7'($urandom_range(0, 1));
            else cmd[6:0] = 7'($urandom_range(0, NR + 2));
            cmd[7] = 1'($urandom_range(0, 1));
            q = {cmd};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            frame(q);
        end

        #50;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
